// File: rtl/riscv_pkg.sv
// Shared RISC core definitions: datapath width, the canonical NOP and fetch FSM states.
package riscv_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   typedef enum logic {
      FETCH = 1'b0,  // normal sequential fetch
      DROP  = 1'b1   // waiting to swallow one response abandoned by a redirect
   } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry instruction buffer between fetch and decode. Flush wins over load,
// load wins over a plain transfer, so a same-cycle transfer+refill keeps valid high.
module fetch_out_buf
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            load,
   input  logic [31:0]     load_instr,
   input  logic [XLEN-1:0] load_pc,
   input  logic            out_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            valid
);

   // Buffer contents and valid flag; a flushed slot shows a NOP.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
         instr_pc <= '0;
      end else if (flush) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= load_instr;
         instr_pc <= load_pc;
      end else if (valid && out_ready) begin
         valid    <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns PCF, talks to instruction memory over req/ready and hands
// words to decode through fetch_out_buf. A redirect that lands while a request
// is still outstanding parks the FSM in DROP so the stale response is eaten.
module pc_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] PCF,
   input  logic [XLEN-1:0] PCPlus4F,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     InstrF,
   output logic [XLEN-1:0] InstrPCF,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic            misalign_f,
   output logic [XLEN-1:0] BadAddrF
);

   fetch_state_t    state_q, state_d;
   logic            pend;
   logic [XLEN-1:0] drop_addr;
   logic            stall;       // request presented but not answered this cycle
   logic            load;
   logic            misaligned;

   assign stall      = imem_req & ~imem_ready;
   assign misaligned = |PCTargetE[1:0];
   // Only a completed FETCH request without a competing redirect reaches decode.
   assign load       = (state_q == FETCH) & imem_req & imem_ready & ~PCSrcE;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // FSM next state: enter DROP only when a redirect abandons an unanswered request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (PCSrcE && stall) state_d = DROP;
         DROP:    if (imem_ready)      state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // FSM outputs: memory request. A pending request keeps req/addr stable until ready.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = PCF;
      if (rst_n) begin
         case (state_q)
            FETCH: begin
               imem_req  = pend | ~instr_valid | instr_ready;
               imem_addr = PCF;
            end
            DROP: begin
               imem_req  = 1'b1;
               imem_addr = drop_addr;
            end
            default: ;
         endcase
      end
   end

   // PC, pending flag, abandoned address and misalign reporting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         PCF        <= RESET_PC;
         pend       <= 1'b0;
         drop_addr  <= '0;
         misalign_f <= 1'b0;
         BadAddrF   <= '0;
      end else begin
         misalign_f <= 1'b0;
         if (imem_req) pend <= ~imem_ready;
         if (PCSrcE) begin
            PCF <= misaligned ? TRAP_VEC : PCTargetE;
            if (misaligned) begin
               misalign_f <= 1'b1;
               BadAddrF   <= PCTargetE;
            end
            // A redirect while already in DROP keeps the original abandoned address.
            if (state_q == FETCH && stall) drop_addr <= imem_addr;
         end else if (load) begin
            PCF <= PCPlus4F;
         end
      end
   end

   fetch_out_buf u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (PCSrcE),
      .load       (load),
      .load_instr (imem_rdata),
      .load_pc    (PCF),
      .out_ready  (instr_ready),
      .instr      (InstrF),
      .instr_pc   (InstrPCF),
      .valid      (instr_valid)
   );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Memory returns ~addr so every expected
// word is easy to compute by hand; the PC+4 adder lives here as it does in the core.
module tb_pc_fetch_unit;
   import riscv_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [31:0]     PCF, PCPlus4F, PCTargetE, imem_addr, imem_rdata;
   logic [31:0]     InstrF, InstrPCF, BadAddrF;
   logic            PCSrcE, imem_req, imem_ready, instr_valid, instr_ready, misalign_f;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign PCPlus4F   = PCF + 32'd4;
   assign imem_rdata = ~imem_addr;

   pc_fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .PCF        (PCF),
      .PCPlus4F   (PCPlus4F),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .InstrF     (InstrF),
      .InstrPCF   (InstrPCF),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .misalign_f (misalign_f),
      .BadAddrF   (BadAddrF)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; PCSrcE = 1'b0; PCTargetE = '0; imem_ready = 1'b1; instr_ready = 1'b1;
      tick(); tick();
      // reset state
      chk("rst_req",   {31'd0, imem_req},    32'd0);
      chk("rst_pcf",   PCF,                  32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", InstrF,               32'h0000_0013);
      chk("rst_ipc",   InstrPCF,             32'd0);
      chk("rst_mis",   {31'd0, misalign_f},  32'd0);
      chk("rst_bad",   BadAddrF,             32'd0);

      // streaming fetch
      rst_n = 1'b1; #1;
      chk("s0_req",  {31'd0, imem_req}, 32'd1);
      chk("s0_addr", imem_addr,         32'd0);
      tick();
      chk("s1_pcf",   PCF,                  32'd4);
      chk("s1_instr", InstrF,               32'hFFFF_FFFF);
      chk("s1_ipc",   InstrPCF,             32'd0);
      chk("s1_valid", {31'd0, instr_valid}, 32'd1);
      tick();
      chk("s2_pcf",   PCF,      32'd8);
      chk("s2_instr", InstrF,   32'hFFFF_FFFB);
      chk("s2_ipc",   InstrPCF, 32'd4);

      // memory stalls for three cycles at address 8
      imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("w_req",   {31'd0, imem_req},    32'd1);
         chk("w_addr",  imem_addr,            32'd8);
         chk("w_pcf",   PCF,                  32'd8);
         chk("w_valid", {31'd0, instr_valid}, 32'd0);
      end
      imem_ready = 1'b1;
      tick();
      chk("w_done_instr", InstrF,               32'hFFFF_FFF7);
      chk("w_done_ipc",   InstrPCF,             32'd8);
      chk("w_done_valid", {31'd0, instr_valid}, 32'd1);
      chk("w_done_pcf",   PCF,                  32'h0000_000C);

      // decode back-pressure
      instr_ready = 1'b0; #1;
      chk("bp_req", {31'd0, imem_req}, 32'd0);
      tick(); tick();
      chk("bp_instr", InstrF,               32'hFFFF_FFF7);
      chk("bp_ipc",   InstrPCF,             32'd8);
      chk("bp_pcf",   PCF,                  32'h0000_000C);
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1; #1;
      chk("bp_rel_req", {31'd0, imem_req}, 32'd1);
      tick();
      chk("bp_rel_ipc", InstrPCF, 32'h0000_000C);
      chk("bp_rel_pcf", PCF,      32'h0000_0010);

      // redirect while request to 0x10 is outstanding
      imem_ready = 1'b0;
      tick();
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0040;
      tick();
      PCSrcE = 1'b0;
      chk("dr_req",   {31'd0, imem_req},    32'd1);
      chk("dr_addr",  imem_addr,            32'h0000_0010);
      chk("dr_pcf",   PCF,                  32'h0000_0040);
      chk("dr_valid", {31'd0, instr_valid}, 32'd0);
      chk("dr_instr", InstrF,               32'h0000_0013);
      imem_ready = 1'b1;
      tick();
      chk("dr_disc_valid", {31'd0, instr_valid}, 32'd0);
      chk("dr_disc_pcf",   PCF,                  32'h0000_0040);
      chk("dr_next_addr",  imem_addr,            32'h0000_0040);
      tick();
      chk("dr_new_instr", InstrF,   32'hFFFF_FFBF);
      chk("dr_new_ipc",   InstrPCF, 32'h0000_0040);
      chk("dr_new_pcf",   PCF,      32'h0000_0044);

      // misaligned redirect target
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0042;
      tick();
      PCSrcE = 1'b0;
      chk("ma_pcf",   PCF,                  32'h0000_0100);
      chk("ma_flag",  {31'd0, misalign_f},  32'd1);
      chk("ma_bad",   BadAddrF,             32'h0000_0042);
      chk("ma_valid", {31'd0, instr_valid}, 32'd0);
      tick();
      chk("ma_pulse", {31'd0, misalign_f}, 32'd0);
      chk("ma_hold",  BadAddrF,            32'h0000_0042);
      chk("ma_ipc",   InstrPCF,            32'h0000_0100);

      // wrap at top of address space
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
      tick();
      PCSrcE = 1'b0;
      chk("wr_pcf", PCF, 32'hFFFF_FFFC);
      tick();
      chk("wr_instr", InstrF,   32'h0000_0003);
      chk("wr_ipc",   InstrPCF, 32'hFFFF_FFFC);
      chk("wr_pcf0",  PCF,      32'd0);

      // reset in the middle of a memory wait
      tick();
      chk("mr_pcf", PCF, 32'd4);
      imem_ready = 1'b0;
      tick();
      rst_n = 1'b0; #1;
      chk("mr_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("mr_pcf_rst", PCF,                  32'd0);
      chk("mr_valid",   {31'd0, instr_valid}, 32'd0);
      rst_n = 1'b1; imem_ready = 1'b1; #1;
      chk("mr_addr", imem_addr, 32'd0);
      tick();
      chk("mr_ipc",   InstrPCF,             32'd0);
      chk("mr_vld",   {31'd0, instr_valid}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
